// File: rtl/aes_ro_sequencer.sv
// aes_ro_sequencer: sequences ring-oscillator enables, AES loads and a scope trigger for one capture campaign.
module aes_ro_sequencer #(
    parameter int NUM_RO = 8,
    parameter int DLY_W  = 16,
    parameter int REP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DLY_W-1:0]  pre_dly_i,
    input  logic [DLY_W-1:0]  post_dly_i,
    input  logic [REP_W-1:0]  rep_i,
    input  logic [NUM_RO-1:0] ro_mask_i,
    input  logic              aes_busy_i,
    output logic              aes_load_o,
    output logic [NUM_RO-1:0] ro_en_o,
    output logic              trig_o,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [REP_W-1:0]  enc_cnt_o
);
    typedef enum logic [2:0] {IDLE, PRE, LOAD, WAITB, RUN, POST, FIN} state_t;
    state_t state, state_nx;
    logic [DLY_W-1:0] cnt, post_q;
    logic [REP_W-1:0] rep_q, enc_q;
    logic [NUM_RO-1:0] mask_q;
    logic [1:0] wcnt;
    logic err_q, last_dly, timeout;
    logic [REP_W:0] enc_inc;
    assign enc_inc = {1'b0, enc_q} + (REP_W+1)'(1);
    // a loaded count of 0 or 1 both mean this is the final delay cycle
    assign last_dly = cnt <= DLY_W'(1);
    assign timeout = !aes_busy_i && wcnt == 2'd3;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_i ? PRE : IDLE;
            PRE:     state_nx = last_dly ? LOAD : PRE;
            LOAD:    state_nx = WAITB;
            WAITB:   state_nx = aes_busy_i ? RUN : timeout ? FIN : WAITB;
            RUN:     state_nx = aes_busy_i ? RUN : enc_inc < {1'b0, rep_q} ? LOAD : POST;
            POST:    state_nx = last_dly ? FIN : POST;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign ready_o    = state == IDLE;
    assign aes_load_o = state == LOAD;
    assign trig_o     = state inside {LOAD, WAITB, RUN};
    assign done_o     = state == FIN;
    assign ro_en_o    = (state inside {PRE, LOAD, WAITB, RUN, POST}) ? mask_q : '0;
    assign err_o      = err_q;
    assign enc_cnt_o  = enc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            post_q <= '0;
            rep_q  <= '0;
            enc_q  <= '0;
            mask_q <= '0;
            wcnt   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    cnt    <= pre_dly_i;
                    post_q <= post_dly_i;
                    rep_q  <= (rep_i == '0) ? REP_W'(1) : rep_i;
                    mask_q <= ro_mask_i;
                    enc_q  <= '0;
                    err_q  <= 1'b0;
                end
                PRE, POST: if (!last_dly) cnt <= cnt - DLY_W'(1);
                LOAD: wcnt <= '0;
                WAITB: begin
                    wcnt <= wcnt + 2'd1;
                    if (timeout) err_q <= 1'b1;
                end
                RUN: if (!aes_busy_i) begin
                    enc_q <= enc_inc[REP_W] ? enc_q : enc_inc[REP_W-1:0];
                    cnt   <= post_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ro_sequencer.sv
// tb_aes_ro_sequencer: directed campaigns checked every cycle against a phase-length trace model.
module tb_aes_ro_sequencer;
    logic clk, rst_n, start_i, aes_busy_i, aes_load_o, trig_o, ready_o, done_o, err_o;
    logic [15:0] pre_dly_i, post_dly_i;
    logic [7:0] rep_i, ro_mask_i, ro_en_o, enc_cnt_o;
    logic model_busy, extra_busy, never_busy;
    int blen, checks, failures, loads, trigs, dones, readies, ros;
    typedef struct packed {
        logic       load;
        logic [7:0] ro;
        logic       trig, ready, done, err;
        logic [7:0] enc;
    } ent_t;
    ent_t q[$];
    logic h_err;
    logic [7:0] h_enc;
    aes_ro_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pre_dly_i(pre_dly_i),
        .post_dly_i(post_dly_i), .rep_i(rep_i), .ro_mask_i(ro_mask_i),
        .aes_busy_i(aes_busy_i), .aes_load_o(aes_load_o), .ro_en_o(ro_en_o),
        .trig_o(trig_o), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
        .enc_cnt_o(enc_cnt_o)
    );
    assign aes_busy_i = model_busy | extra_busy;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // AES core model: busy rises the cycle after a load and stays high for blen cycles
    always begin
        @(negedge clk);
        if (aes_load_o === 1'b1 && !never_busy) begin
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (blen) @(posedge clk);
            #1 model_busy = 1'b0;
        end
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask
    function automatic ent_t mk(input logic l, input logic [7:0] r, input logic t, input logic rd,
                                input logic dn, input logic er, input logic [7:0] en);
        return ent_t'({l, r, t, rd, dn, er, en});
    endfunction
    // expected trace of a campaign, one entry per cycle, starting with the idle cycle that carries start
    task automatic build(input int pre, input int post, input int rep, input logic [7:0] mask,
                         input bit never, input int bl);
        int np, nq, r;
        np = (pre == 0) ? 1 : pre;
        nq = (post == 0) ? 1 : post;
        r  = (rep == 0) ? 1 : rep;
        q.push_back(mk(0, 8'h00, 0, 1, 0, h_err, h_enc));
        repeat (np) q.push_back(mk(0, mask, 0, 0, 0, 0, 8'h00));
        if (never) begin
            q.push_back(mk(1, mask, 1, 0, 0, 0, 8'h00));
            repeat (4) q.push_back(mk(0, mask, 1, 0, 0, 0, 8'h00));
            q.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h00));
            h_err = 1'b1;
            h_enc = 8'h00;
        end else begin
            for (int k = 0; k < r; k++) begin
                q.push_back(mk(1, mask, 1, 0, 0, 0, 8'(k)));
                q.push_back(mk(0, mask, 1, 0, 0, 0, 8'(k)));
                repeat (bl) q.push_back(mk(0, mask, 1, 0, 0, 0, 8'(k)));
            end
            repeat (nq) q.push_back(mk(0, mask, 0, 0, 0, 0, 8'(r)));
            q.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'(r)));
            h_err = 1'b0;
            h_enc = 8'(r);
        end
    endtask
    task automatic cyc();
        ent_t e, a;
        @(negedge clk);
        e = mk(0, 8'h00, 0, 1, 0, h_err, h_enc);
        if (q.size() > 0) e = q.pop_front();
        a = ent_t'({aes_load_o, ro_en_o, trig_o, ready_o, done_o, err_o, enc_cnt_o});
        chk("trace", 32'(a), 32'(e));
        loads   += 32'(aes_load_o);
        trigs   += 32'(trig_o);
        dones   += 32'(done_o);
        readies += 32'(ready_o);
        if (ro_en_o != 8'h00) ros++;
        @(posedge clk);
        #1;
    endtask
    task automatic run(input int pre, input int post, input int rep, input logic [7:0] mask,
                       input bit never, input bit spam, input bit glitch, input int bl);
        int np, i;
        np = (pre == 0) ? 1 : pre;
        never_busy = never;
        blen = bl;
        {loads, trigs, dones, readies, ros} = '0;
        pre_dly_i = 16'(pre);
        post_dly_i = 16'(post);
        rep_i = 8'(rep);
        ro_mask_i = mask;
        start_i = 1'b1;
        extra_busy = glitch;
        build(pre, post, rep, mask, never, bl);
        cyc();
        start_i = 1'b0;
        i = 0;
        while (q.size() > 0) begin
            start_i = spam && q.size() > 3 && i % 2 == 1;
            if (spam) begin
                pre_dly_i = 16'($urandom);
                post_dly_i = 16'($urandom);
                rep_i = 8'($urandom);
                ro_mask_i = 8'($urandom);
            end
            extra_busy = glitch && i < np - 1;
            cyc();
            i++;
        end
        start_i = 1'b0;
        extra_busy = 1'b0;
    endtask
    initial begin
        {checks, failures, loads, trigs, dones, readies, ros} = '0;
        {start_i, model_busy, extra_busy, never_busy} = '0;
        {pre_dly_i, post_dly_i, rep_i, ro_mask_i} = '0;
        blen = 1;
        h_err = 1'b0;
        h_enc = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_ro", 32'(ro_en_o), 0);
        chk("rst_flags", 32'({aes_load_o, trig_o, done_o, err_o}), 0);
        chk("rst_enc", 32'(enc_cnt_o), 0);
        rst_n = 1'b1;
        repeat (3) cyc();
        run(3, 2, 1, 8'h0F, 0, 0, 0, 11);
        chk("basic_loads", 32'(loads), 1);
        chk("basic_trig", 32'(trigs), 13);
        chk("basic_ro", 32'(ros), 18);
        chk("basic_done", 32'(dones), 1);
        chk("basic_enc", 32'(enc_cnt_o), 1);
        repeat (2) cyc();
        run(5, 1, 0, 8'h81, 0, 0, 0, 3);
        chk("rep0_loads", 32'(loads), 1);
        chk("rep0_enc", 32'(enc_cnt_o), 1);
        run(4, 3, 3, 8'h5A, 0, 0, 1, 4);
        chk("rep3_loads", 32'(loads), 3);
        chk("rep3_ready", 32'(readies), 1);
        chk("rep3_enc", 32'(enc_cnt_o), 3);
        run(2, 2, 2, 8'hC3, 1, 0, 0, 0);
        chk("tmo_err", 32'(err_o), 1);
        chk("tmo_loads", 32'(loads), 1);
        chk("tmo_done", 32'(dones), 1);
        chk("tmo_trig", 32'(trigs), 5);
        repeat (3) cyc();
        chk("tmo_sticky", 32'(err_o), 1);
        run(1, 1, 1, 8'h11, 0, 0, 0, 2);
        chk("tmo_clear", 32'(err_o), 0);
        run(2, 3, 2, 8'hA5, 0, 1, 0, 6);
        chk("spam_done", 32'(dones), 1);
        chk("spam_loads", 32'(loads), 2);
        chk("spam_enc", 32'(enc_cnt_o), 2);
        run(0, 0, 1, 8'hFF, 0, 0, 0, 11);
        chk("zero_ro", 32'(ros), 15);
        repeat (2) cyc();
        never_busy = 1'b0;
        blen = 5;
        pre_dly_i = 16'd2;
        post_dly_i = 16'd2;
        rep_i = 8'd4;
        ro_mask_i = 8'h77;
        start_i = 1'b1;
        build(2, 2, 4, 8'h77, 0, 5);
        cyc();
        start_i = 1'b0;
        repeat (12) cyc();
        chk("mid_in_run", 32'({trig_o, enc_cnt_o}), 32'h101);
        rst_n = 1'b0;
        while (q.size() > 1) void'(q.pop_back());
        h_enc = 8'h00;
        h_err = 1'b0;
        dones = 0;
        cyc();
        rst_n = 1'b1;
        chk("mid_ro", 32'(ro_en_o), 0);
        chk("mid_enc", 32'(enc_cnt_o), 0);
        chk("mid_ready", 32'(ready_o), 1);
        repeat (10) cyc();
        chk("mid_done", 32'(dones), 0);
        run(65535, 5, 1, 8'h3C, 0, 0, 0, 2);
        chk("long_ro", 32'(ros), 65544);
        chk("long_loads", 32'(loads), 1);
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_ro_sequencer.md
AES_RO_SEQUENCER -- requirements
Module: aes_ro_sequencer

Interface
REQ-001 SHALL have parameter NUM_RO, default 8, meaning the number of ring-oscillator enables driven.
REQ-002 SHALL have parameter DLY_W, default 16, meaning the width of the pre/post delay counters.
REQ-003 SHALL have parameter REP_W, default 8, meaning the width of the encryption-repeat count.
REQ-004 SHALL have ports as follows:
- clk  in  1  crypto clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle request to begin a campaign.
- pre_dly_i  in  DLY_W  cycles of RO-on before the first load.
- post_dly_i  in  DLY_W  cycles of RO-on after the last busy falls.
- rep_i  in  REP_W  number of back-to-back encryptions; 0 is treated as 1.
- ro_mask_i  in  NUM_RO  selects which oscillators are enabled.
- aes_busy_i  in  1  AES core busy.
- aes_load_o  out  1  one-cycle load strobe to the AES core.
- ro_en_o  out  NUM_RO  per-oscillator enable.
- trig_o  out  1  scope trigger.
- ready_o  out  1  idle and accepting start_i.
- done_o  out  1  one-cycle campaign-complete pulse.
- err_o  out  1  sticky busy-timeout flag.
- enc_cnt_o  out  REP_W  encryptions completed in the current or last campaign.

Function
REQ-005 SHALL implement states IDLE, PRE, LOAD, WAITB, RUN, POST, FIN.
REQ-006 IDLE: ready_o=1; on start_i=1, SHALL latch pre_dly_i, post_dly_i, rep_i (0 becomes 1) and ro_mask_i, clear enc_cnt_o and err_o, and go to PRE.
REQ-007 start_i outside IDLE SHALL be ignored; configuration inputs SHALL be sampled only on an accepted start.
REQ-008 PRE SHALL last exactly the latched pre-delay count in cycles, then go to LOAD; a pre-delay of 0 SHALL go to LOAD on the cycle after PRE is entered (1 cycle in PRE).
REQ-009 LOAD SHALL assert aes_load_o for exactly one cycle, then go to WAITB.
REQ-010 WAITB SHALL go to RUN when aes_busy_i=1.
REQ-011 If aes_busy_i is not seen within 4 cycles of entering WAITB, the block SHALL set err_o and go to FIN.
REQ-012 RUN SHALL wait for aes_busy_i=0, then increment enc_cnt_o. It SHALL go to LOAD if enc_cnt_o (after incrementing) is less than the latched repeat count, otherwise to POST.
REQ-013 POST SHALL last the latched post-delay count in cycles, with 0 meaning 1 cycle, then go to FIN.
REQ-014 FIN SHALL assert done_o for one cycle and return to IDLE; ready_o SHALL be 1 on the following cycle.
REQ-015 ro_en_o SHALL equal the latched mask in PRE, LOAD, WAITB, RUN and POST, and SHALL be 0 in all other states.
REQ-016 trig_o SHALL be 1 from the LOAD cycle of the first encryption through the cycle busy falls on the last encryption, and 0 otherwise.
REQ-017 Delay counters SHALL not wrap; a delay of 2^DLY_W-1 SHALL produce exactly that many cycles.
REQ-018 enc_cnt_o SHALL saturate at 2^REP_W-1 and hold its value after FIN until the next accepted start.
REQ-019 err_o SHALL remain set until the next accepted start or reset.
REQ-020 aes_busy_i high during IDLE or PRE SHALL have no effect on the state machine.

Reset
REQ-021 With rst_n=0 at a clk edge, the block SHALL enter IDLE with ready_o=1 and aes_load_o, ro_en_o, trig_o, done_o, err_o and enc_cnt_o all 0.
REQ-022 Reset mid-campaign SHALL abort immediately, without a done_o pulse, and ro_en_o SHALL be 0 on the next cycle.

Verification
REQ-023 pre=3, post=2, rep=1, mask=8'h0F, AES model busy 1 cycle after load for 11 cycles:
- ro_en_o=8'h0F for 3 cycles, then one aes_load_o pulse.
- trig_o high for 13 cycles.
- POST lasts 2 cycles, then done_o and enc_cnt_o=1.
REQ-024 rep=0 -> exactly one aes_load_o pulse; rep=3 -> three loads with no IDLE between them, enc_cnt_o=3.
REQ-025 AES model never asserts busy -> err_o=1 by 5 cycles after load, done_o pulse, no further loads; err_o clears on the next start.
REQ-026 start_i pulsed repeatedly during RUN -> no effect; the campaign completes once.
REQ-027 rst_n low during RUN of a rep=4 campaign -> next cycle IDLE, ro_en_o=0, enc_cnt_o=0, no done_o.
REQ-028 pre=0, post=0 -> PRE and POST each last 1 cycle; mask=8'hFF appears on ro_en_o throughout.
